// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: clog2 of the operand width, never below one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder built from propagate/generate terms.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;

  // Propagate/generate form keeps the carry path a single AND-OR.
  always_comb begin
    p  = x ^ y;
    g  = x & y;
    s  = p ^ ci;
    co = g | (p & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused for WIDTH cycles,
// LSB first, with an optional lower-part-OR approximate mode.
//
// Handshake: start is accepted only in IDLE (busy=0) on a rising edge; the
// operands, cin and approx_en are captured on that edge. done is a one-cycle
// pulse that marks sum/cout as valid; sum/cout hold until the next result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic             approx_q;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic             in_approx;
  logic             approx_last;
  logic             bit_s;
  logic             bit_c;

  fa_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Bit selection: approximate low bits bypass the cell; the carry is cut
  // inside the approximate region and re-seeded from its top bit.
  always_comb begin
    last_bit    = (cnt == CW'(WIDTH - 1));
    in_approx   = approx_q && (APPROX_BITS > 0) && (int'(cnt) < APPROX_BITS);
    approx_last = in_approx && (int'(cnt) == APPROX_BITS - 1);
    bit_s       = fa_s;
    bit_c       = fa_co;
    if (in_approx) begin
      bit_s = a_sr[0] | b_sr[0];
      bit_c = approx_last ? (a_sr[0] & b_sr[0]) : 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode: RUN exits on the last bit, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)    state_nx = ST_RUN;
      ST_RUN:  if (last_bit) state_nx = ST_DONE;
      ST_DONE:               state_nx = ST_IDLE;
      default:               state_nx = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    dbg_state = state;
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, publish at end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      approx_q <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            approx_q <= approx_en;
            cnt      <= '0;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {bit_s, res_sr[WIDTH-1:1]};
          carry  <= bit_c;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= {bit_s, res_sr[WIDTH-1:1]};
            cout <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition sequencer. It time-shares one 1-bit full-adder cell across WIDTH cycles to add two WIDTH-bit operands, LSB first, with a start/done handshake.
- An optional lower-part-OR approximate mode cuts the carry chain in the low APPROX_BITS bits. This gives the approximate-multiplier partial-product accumulation path a cheap adder whose accuracy can be traded off.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- APPROX_BITS, 0, number of low bits computed approximately when approx_en=1 (0..WIDTH; 0 = approx mode has no effect).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, sampled with accepted start
- b  input  WIDTH  operand B, sampled with accepted start
- cin  input  1  carry-in, sampled with accepted start
- approx_en  input  1  approximate mode, sampled with accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, held until the next result is written
- cout  output  1  final carry-out, held with sum

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst. It overrides everything on the next edge, including mid-operation.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry flop=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on an edge with start=1. That edge latches a, b, cin into the carry flop, and approx_en. Counter is cleared to 0.
  - RUN: each edge processes bit i=counter.
    - Full-adder cell inputs: a_sr[0], b_sr[0], carry flop.
    - Cell sum is shifted into the MSB of the internal result register (LSB-first fill). Operand registers shift right. Carry flop takes the cell carry. Counter increments.
  - RUN→DONE on the edge processing i=WIDTH-1. On that same edge, the full result is copied to sum and the final carry to cout.
  - DONE→IDLE unconditionally on the next edge.
- Latency: the start-accept edge is edge 0. Bits are processed on edges 1..WIDTH. done=1 for exactly the cycle after edge WIDTH. busy=1 from after edge 0 until after edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. Back-to-back is allowed: start may be held high during DONE and will be accepted on the edge after DONE→IDLE.
- start while RUN or DONE: ignored, no queuing. Input changes during RUN have no effect.
- sum/cout change only on the RUN→DONE edge (or reset). They are never partial values.
- Approximate mode (latched approx_en=1 and APPROX_BITS>0):
  - For i < APPROX_BITS: result bit = a_i | b_i.
  - Carry flop is forced to 0 after each such bit, except that after bit APPROX_BITS-1 it loads a_i & b_i.
  - Latched cin is ignored.
  - Bits ≥ APPROX_BITS use the exact full-adder cell.
  - APPROX_BITS=WIDTH: cout = a_{W-1} & b_{W-1}.
- Exact mode: sum/cout equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Counter width: clog2(WIDTH). Wrap-around is never reached because the RUN exit is decoded at WIDTH-1.

Decomposition:
- Shared package:
  - FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Counter-width function/constant.
- One sub-module: fa_cell.
  - Purely combinational 1-bit full adder (inputs x, y, ci; outputs s, co).
  - Built from propagate/generate: s = p^ci, co = g | p&ci.
  - Instantiated once.
- The approximate-bit mux lives in serial_add_ctrl around the cell.

Test Plan:
- WIDTH=8, exact: a=0x5A, b=0x3C, cin=0, start pulse → busy after edge 0; done pulse after edge 8; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0.
- APPROX_BITS=4, approx_en=1: a=0x0F, b=0x01 → sum=0x0F, cout=0 (exact would give 0x10). Same operands with approx_en=0 → sum=0x10.
- Mid-run rules:
  - start with a=0x11, b=0x22 accepted, then start pulsed again at cycle 3 with different operands → ignored; result 0x33, single done.
  - start held continuously → done pulses every 10 cycles, each with the freshly sampled operands.
- Reset mid-operation: rst=1 at RUN bit 4 → next cycle busy=0, done=0, sum=0, cout=0. A subsequent start with a=0x01, b=0x01 → sum=0x02, with no leftover carry.
